// File: rtl/upc_pkg.sv
// Shared types, default lookup masks and the saturating-count helper
// for the UPC checkout station.
package upc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ALARM  = 2'd2
    } state_e;

    // Default masks for 3-bit codes, upc = {U,P,C}:
    //   discounted  = U&C | P             -> codes 2,3,5,6,7
    //   stolen      = ~P & ~(C&~U)        -> codes 0,4,5 (when unmarked)
    localparam int         UPC_W_DEF          = 3;
    localparam logic [7:0] DISCOUNT_MASK_DEF  = 8'b1110_1100;
    localparam logic [7:0] EXPENSIVE_MASK_DEF = 8'b0011_0001;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/upc_classifier.sv
// Combinational item classifier: looks the code up in the discount and
// expensive masks; an expensive item without a mark is treated as stolen.
module upc_classifier #(
    parameter int                      UPC_W          = 3,
    parameter logic [2**UPC_W-1:0]     DISCOUNT_MASK  = '0,
    parameter logic [2**UPC_W-1:0]     EXPENSIVE_MASK = '0
) (
    input  logic [UPC_W-1:0] upc,
    input  logic             mark,
    output logic             disc,
    output logic             stol
);

    // Mask lookup by code index.
    always_comb begin
        disc = DISCOUNT_MASK[upc];
        stol = EXPENSIVE_MASK[upc] & ~mark;
    end

endmodule

// File: rtl/upc_checkout_fsm.sv
// Checkout station: transaction FSM (IDLE/ACTIVE/ALARM), saturating item
// and discount counters, and one-cycle discount/stolen/done pulses.
module upc_checkout_fsm
    import upc_pkg::*;
#(
    parameter int                  UPC_W          = UPC_W_DEF,
    parameter int                  CNT_W          = 4,
    parameter logic [2**UPC_W-1:0] DISCOUNT_MASK  = DISCOUNT_MASK_DEF,
    parameter logic [2**UPC_W-1:0] EXPENSIVE_MASK = EXPENSIVE_MASK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             scan,
    input  logic [UPC_W-1:0] upc,
    input  logic             mark,
    input  logic             checkout,
    input  logic             ack,
    output logic             discount,
    output logic             stolen,
    output logic [CNT_W-1:0] item_count,
    output logic [CNT_W-1:0] discount_count,
    output logic             alarm,
    output logic             busy,
    output logic             done
);

    localparam logic [31:0] CNT_MAX = 32'((1 << CNT_W) - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] item_count_q, item_count_d;
    logic [CNT_W-1:0] discount_count_q, discount_count_d;
    logic             discount_q, discount_d;
    logic             stolen_q, stolen_d;
    logic             done_q, done_d;
    logic             disc, stol;

    upc_classifier #(
        .UPC_W         (UPC_W),
        .DISCOUNT_MASK (DISCOUNT_MASK),
        .EXPENSIVE_MASK(EXPENSIVE_MASK)
    ) u_classifier (
        .upc (upc),
        .mark(mark),
        .disc(disc),
        .stol(stol)
    );

    // Next-state, counter and pulse logic for the current state and inputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; a missing default here would infer a latch.
        state_d          = state_q;
        item_count_d     = item_count_q;
        discount_count_d = discount_count_q;
        discount_d       = 1'b0;
        stolen_d         = 1'b0;
        done_d           = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A scan coinciding with start is dropped.
                if (start) begin
                    state_d          = ST_ACTIVE;
                    item_count_d     = '0;
                    discount_count_d = '0;
                end
            end
            ST_ACTIVE: begin
                if (scan) begin
                    item_count_d = CNT_W'(sat_inc(32'(item_count_q), CNT_MAX));
                    if (disc) begin
                        discount_count_d = CNT_W'(sat_inc(32'(discount_count_q), CNT_MAX));
                    end
                    discount_d = disc;
                    stolen_d   = stol;
                end
                // A theft pre-empts any checkout issued in the same cycle.
                if (scan && stol) begin
                    state_d = ST_ALARM;
                end else if (checkout) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ALARM: begin
                if (ack) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments so every register samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q          <= ST_IDLE;
            item_count_q     <= '0;
            discount_count_q <= '0;
            discount_q       <= 1'b0;
            stolen_q         <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            item_count_q     <= item_count_d;
            discount_count_q <= discount_count_d;
            discount_q       <= discount_d;
            stolen_q         <= stolen_d;
            done_q           <= done_d;
        end
    end

    assign discount       = discount_q;
    assign stolen         = stolen_q;
    assign item_count     = item_count_q;
    assign discount_count = discount_count_q;
    assign alarm          = (state_q == ST_ALARM);
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_upc_checkout_fsm.sv
// Scoreboard bench for upc_checkout_fsm. The driver applies one input
// vector per cycle, advances a behavioural model derived from the lab
// truth table, and queues the expected outputs; a monitor on the falling
// edge pops and compares. Two instances share the stimulus: the default
// 4-bit counters and a 2-bit variant that exercises saturation often.
module tb_upc_checkout_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, scan = 1'b0, mark = 1'b0, checkout = 1'b0, ack = 1'b0;
    logic [2:0] upc = 3'd0;

    logic       discount_a, stolen_a, alarm_a, busy_a, done_a;
    logic [3:0] item_count_a, discount_count_a;
    logic       discount_b, stolen_b, alarm_b, busy_b, done_b;
    logic [1:0] item_count_b, discount_count_b;

    always #5 clk = ~clk;

    upc_checkout_fsm dut_a (
        .clk(clk), .reset(reset), .start(start), .scan(scan), .upc(upc),
        .mark(mark), .checkout(checkout), .ack(ack),
        .discount(discount_a), .stolen(stolen_a), .item_count(item_count_a),
        .discount_count(discount_count_a), .alarm(alarm_a), .busy(busy_a), .done(done_a)
    );

    upc_checkout_fsm #(.CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .scan(scan), .upc(upc),
        .mark(mark), .checkout(checkout), .ack(ack),
        .discount(discount_b), .stolen(stolen_b), .item_count(item_count_b),
        .discount_count(discount_count_b), .alarm(alarm_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        bit discount, stolen, alarm, busy, done;
        int items_a, discs_a, items_b, discs_b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- behavioural model ----------------
    localparam int M_CLOSED = 0, M_OPEN = 1, M_THEFT = 2;
    int mode = M_CLOSED;
    int items_a = 0, discs_a = 0, items_b = 0, discs_b = 0;

    function automatic int bump(input int v, input int max_v);
        return (v < max_v) ? v + 1 : max_v;
    endfunction

    // Advance the model by one clock edge with the given inputs; return outputs.
    function automatic exp_t model_step(input bit rst, st, sc, input logic [2:0] u,
                                        input bit m, co, ak);
        exp_t e;
        bit   pu, pp, pc, is_disc, is_stol;
        pu = u[2]; pp = u[1]; pc = u[0];
        is_disc = (pu & pc) | pp;
        is_stol = ~m & ~pp & ~(pc & ~pu);
        e.discount = 0; e.stolen = 0; e.done = 0;
        if (rst) begin
            mode = M_CLOSED;
            items_a = 0; discs_a = 0; items_b = 0; discs_b = 0;
        end else if (mode == M_CLOSED) begin
            if (st) begin
                mode = M_OPEN;
                items_a = 0; discs_a = 0; items_b = 0; discs_b = 0;
            end
        end else if (mode == M_OPEN) begin
            if (sc) begin
                items_a = bump(items_a, 15);
                items_b = bump(items_b, 3);
                if (is_disc) begin
                    discs_a = bump(discs_a, 15);
                    discs_b = bump(discs_b, 3);
                end
                e.discount = is_disc;
                e.stolen   = is_stol;
            end
            if (sc && is_stol) mode = M_THEFT;
            else if (co) begin
                mode   = M_CLOSED;
                e.done = 1;
            end
        end else begin
            if (ak) mode = M_OPEN;
        end
        e.alarm   = (mode == M_THEFT);
        e.busy    = (mode != M_CLOSED);
        e.items_a = items_a; e.discs_a = discs_a;
        e.items_b = items_b; e.discs_b = discs_b;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input bit rst, st, sc, input logic [2:0] u, input bit m, co, ak);
        @(negedge clk);
        #1;
        reset = rst; start = st; scan = sc; upc = u; mark = m; checkout = co; ack = ak;
        exp_q.push_back(model_step(rst, st, sc, u, m, co, ak));
    endtask

    task automatic idle();                                   drive(0, 0, 0, 3'd0, 0, 0, 0); endtask
    task automatic do_start();                               drive(0, 1, 0, 3'd0, 0, 0, 0); endtask
    task automatic do_scan(input logic [2:0] u, input bit m); drive(0, 0, 1, u, m, 0, 0);    endtask
    task automatic do_checkout();                            drive(0, 0, 0, 3'd0, 0, 1, 0); endtask
    task automatic do_ack();                                 drive(0, 0, 0, 3'd0, 0, 0, 1); endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input bit ok, input string got, input string want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at %0t: got %s, want %s", name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string g, w;
            e = exp_q.pop_front();
            w = $sformatf("disc=%0b stol=%0b alarm=%0b busy=%0b done=%0b items=%0d discs=%0d",
                          e.discount, e.stolen, e.alarm, e.busy, e.done, e.items_a, e.discs_a);
            g = $sformatf("disc=%0b stol=%0b alarm=%0b busy=%0b done=%0b items=%0d discs=%0d",
                          discount_a, stolen_a, alarm_a, busy_a, done_a, item_count_a, discount_count_a);
            check("dut_a", g == w, g, w);
            w = $sformatf("disc=%0b stol=%0b alarm=%0b busy=%0b done=%0b items=%0d discs=%0d",
                          e.discount, e.stolen, e.alarm, e.busy, e.done, e.items_b, e.discs_b);
            g = $sformatf("disc=%0b stol=%0b alarm=%0b busy=%0b done=%0b items=%0d discs=%0d",
                          discount_b, stolen_b, alarm_b, busy_b, done_b, item_count_b, discount_count_b);
            check("dut_b_cnt2", g == w, g, w);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        // 1: reset for two cycles, then a scan in IDLE has no effect.
        drive(1, 0, 0, 3'd0, 0, 0, 0);
        drive(1, 0, 0, 3'd0, 0, 0, 0);
        idle();
        do_scan(3'd7, 0);
        idle();

        // 2: normal transaction, counts hold afterwards.
        do_start();
        do_scan(3'd2, 1); do_scan(3'd7, 1); do_scan(3'd1, 1);
        do_checkout();
        idle(); idle();

        // 3: theft, ignored scan during alarm, acknowledge, close.
        do_start();
        do_scan(3'd4, 0);
        do_scan(3'd2, 1);
        do_ack();
        do_checkout();
        idle();

        // 4: saturation (2-bit instance sticks at 3).
        do_start();
        repeat (5) do_scan(3'd3, 1);
        do_checkout();
        idle();

        // 5: same-cycle scan+checkout, then stolen scan+checkout.
        do_start();
        drive(0, 0, 1, 3'd2, 1, 1, 0);
        idle();
        do_start();
        drive(0, 0, 1, 3'd0, 0, 1, 0);
        idle();
        drive(0, 1, 0, 3'd0, 0, 1, 0); // start/checkout ignored in ALARM
        do_ack();
        do_checkout();

        // start and scan together in IDLE: scan dropped.
        drive(0, 1, 1, 3'd7, 1, 0, 0);
        do_checkout();

        // 6: reset while in ALARM with two items counted.
        do_start();
        do_scan(3'd6, 1);
        do_scan(3'd0, 0);
        drive(1, 0, 0, 3'd0, 0, 0, 0);
        idle();

        // Exhaustive sweep of all (upc, mark) pairs.
        do_start();
        for (int i = 0; i < 16; i++) begin
            do_scan(3'(i >> 1), i[0]);
            if (alarm_a === 1'b1 || exp_q.size() > 0) begin
                // acknowledge unconditionally; ack is harmless in ACTIVE
                do_ack();
            end
        end
        do_checkout();
        idle();

        // Random traffic.
        for (int n = 0; n < 500; n++) begin
            drive(($urandom_range(63) == 0), ($urandom_range(5) == 0), ($urandom_range(1) == 0),
                  3'($urandom_range(7)), ($urandom_range(1) == 1),
                  ($urandom_range(9) == 0), ($urandom_range(3) == 0));
        end
        idle();

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
